mem_port_arbiter: RTL

- Shares one single-port, variable-latency memory between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Grants requests, sequences each memory transaction, and returns read data with a one-cycle ready pulse.
- Produces per-requester stall outputs that the top level combines with the hazard enables (FEN/DEN) to freeze the pipeline.
- Data port has priority; a starvation counter guarantees fetch progress; a timeout flags a dead memory.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arb_grant.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared types and access-size encodings for the memory arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  // Addressing-control encodings shared with the memory stage (bit 2 = unsigned)
  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

endpackage

`default_nettype wire

// File: rtl/mem_arb_grant.sv
// ============================================================================
// mem_arb_grant : data-priority grant selection with fetch starvation counter
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   if_req,
  input  logic   dm_req,
  output owner_t grant
);

  localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_full;

  assign starve_full = (starve_cnt == STARVE_LIM);

  always_comb begin
    grant = OWN_NONE;
    if (en) begin
      if (if_req && (!dm_req || starve_full)) begin
        grant = OWN_IF;
      end else if (dm_req) begin
        grant = OWN_DM;
      end
    end
  end

  // Counts data grants that bypassed a waiting fetch; saturates at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else begin
      case (grant)
        OWN_IF: starve_cnt <= '0;
        OWN_DM: begin
          if (!if_req) begin
            starve_cnt <= '0;
          end else if (!starve_full) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one variable-latency memory port between fetch
//                    and data requesters, with timeout abort
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [2:0]        dm_size,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              err_timeout
);

  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state;
  state_t            next_state;
  owner_t            owner;
  owner_t            grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        size_q;
  logic              we_q;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              err_q;
  logic              timeout_hit;

  mem_arb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk    (clk),
    .rst    (rst),
    .en     (state == ST_IDLE),
    .if_req (if_req),
    .dm_req (dm_req),
    .grant  (grant)
  );

  assign timeout_hit = (state == ST_BUSY) && !mem_ack && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (grant != OWN_NONE) next_state = ST_BUSY;
      ST_BUSY: begin
        if (mem_ack) begin
          next_state = ST_RESP;
        end else if (timeout_hit) begin
          next_state = ST_IDLE;
        end
      end
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Request latches and read-data capture; a timeout drops the transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      to_cnt     <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      case (state)
        ST_IDLE: begin
          to_cnt <= '0;
          case (grant)
            OWN_IF: begin
              owner   <= OWN_IF;
              addr_q  <= if_addr;
              wdata_q <= '0;
              size_q  <= SIZE_W;
              we_q    <= 1'b0;
            end
            OWN_DM: begin
              owner   <= OWN_DM;
              addr_q  <= dm_addr;
              wdata_q <= dm_wdata;
              size_q  <= dm_size;
              we_q    <= dm_we;
            end
            default: ;
          endcase
        end
        ST_BUSY: begin
          if (mem_ack) begin
            to_cnt <= '0;
            if (owner == OWN_IF) begin
              if_rdata_q <= mem_rdata;
            end else begin
              dm_rdata_q <= mem_rdata;
            end
          end else if (timeout_hit) begin
            to_cnt <= '0;
            owner  <= OWN_NONE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_RESP: owner <= OWN_NONE;
        default: owner <= OWN_NONE;
      endcase
    end
  end

  assign mem_req     = (state == ST_BUSY);
  assign mem_we      = mem_req & we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_size    = size_q;
  assign if_ready    = (state == ST_RESP) && (owner == OWN_IF);
  assign dm_ready    = (state == ST_RESP) && (owner == OWN_DM);
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign stall_if    = if_req & ~if_ready;
  assign stall_dm    = dm_req & ~dm_ready;
  assign err_timeout = err_q;

endmodule

`default_nettype wire
